// File: rtl/neural_pkg.sv
// Shared lane geometry, mode encodings and tag/result types for the neural SIMD feed path.
package neural_pkg;
  localparam int SIMD_LANES = 4;
  localparam int PIX_W      = 8;
  localparam int WORD_W     = SIMD_LANES * PIX_W;

  typedef enum logic [1:0] {
    MODE_ADD     = 2'd0,
    MODE_SUB     = 2'd1,
    MODE_ABSDIFF = 2'd2,
    MODE_MAC     = 2'd3
  } mode_e;

  typedef struct packed {
    logic                  valid;
    logic [SIMD_LANES-1:0] keep;
    logic                  last;
  } tag_t;

  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic [SIMD_LANES-1:0] keep;
    logic                  last;
  } res_t;
endpackage

// File: rtl/neural_sync_fifo.sv
// Synchronous valid/ready FIFO with occupancy count; DEPTH must be a power of two.
module neural_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         pop_valid,
  input  logic                         pop_ready,
  output logic [WIDTH-1:0]             pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign push_ready = (count != CW'(DEPTH));
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign do_push    = push_valid & push_ready;
  assign do_pop     = pop_valid & pop_ready;

  // Pointers are exactly AW bits wide, so they wrap mod DEPTH for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) count <= do_push ? count + CW'(1) : count - CW'(1);
    end
  end
endmodule

// File: rtl/neural_simd_feeder.sv
// Packs byte-serial pixel pairs into 4-lane SIMD words, issues them under FIFO credit and
// realigns results through a tag pipe. Define NEURAL_FEED_STATS_EN for issue/stall counters.
module neural_simd_feeder
  import neural_pkg::*;
#(
  parameter int SIMD_LAT   = 1,
  parameter int FIFO_DEPTH = 4
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_param,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_pix_t,
  input  logic [7:0]  s_pix_t1,
  input  logic        s_last,
  output logic [1:0]  simd_mode,
  output logic [31:0] simd_rs1,
  output logic [31:0] simd_rs2,
  output logic [31:0] simd_param,
  output logic        simd_issue,
  input  logic [31:0] simd_rd,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last
`ifdef NEURAL_FEED_STATS_EN
  ,
  output logic [31:0] stat_words,
  output logic [31:0] stat_stalls
`endif
);
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam int CW  = $clog2(SIMD_LAT + FIFO_DEPTH + 2);

  logic [1:0]                       idx;
  logic [SIMD_LANES-1:0][PIX_W-1:0] hold_t, hold_t1;
  logic [SIMD_LANES-1:0]            hold_keep, iss_keep;
  mode_e                            hold_mode;
  logic [PIX_W-1:0]                 hold_param;
  logic                             hold_last, iss_last, word_complete;
  logic                             accept, issue_now, credit_ok;
  logic [CW-1:0]                    inflight;
  logic [FCW-1:0]                   fifo_count;
  logic                             fifo_push_ready;
  tag_t [SIMD_LAT-1:0]              tag_pipe;
  res_t                             push_res, head;

  assign credit_ok = (inflight + CW'(fifo_count)) < CW'(FIFO_DEPTH);
  assign issue_now = word_complete & credit_ok;
  assign s_ready   = !rst & (!word_complete | issue_now);
  assign accept    = s_valid & s_ready;

  // Issuing clears the holding regs; a same-cycle accept then lands in lane 0 of the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      hold_t        <= '0;
      hold_t1       <= '0;
      hold_keep     <= '0;
      hold_mode     <= MODE_ADD;
      hold_param    <= '0;
      hold_last     <= 1'b0;
      word_complete <= 1'b0;
    end else begin
      if (issue_now) begin
        hold_t        <= '0;
        hold_t1       <= '0;
        hold_keep     <= '0;
        hold_last     <= 1'b0;
        word_complete <= 1'b0;
      end
      if (accept) begin
        hold_t[idx]    <= s_pix_t;
        hold_t1[idx]   <= s_pix_t1;
        hold_keep[idx] <= 1'b1;
        if (idx == 2'd0) begin
          hold_mode  <= mode_e'(cfg_mode);
          hold_param <= cfg_param;
        end
        if (idx == 2'd3 || s_last) begin
          word_complete <= 1'b1;
          hold_last     <= s_last;
          idx           <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      simd_issue <= 1'b0;
      simd_mode  <= '0;
      simd_rs1   <= '0;
      simd_rs2   <= '0;
      simd_param <= '0;
      iss_keep   <= '0;
      iss_last   <= 1'b0;
    end else begin
      simd_issue <= issue_now;
      if (issue_now) begin
        simd_mode  <= hold_mode;
        simd_rs1   <= hold_t;
        simd_rs2   <= hold_t1;
        simd_param <= {SIMD_LANES{hold_param}};
        iss_keep   <= hold_keep;
        iss_last   <= hold_last;
      end
    end
  end

  // Stage 0 loads one cycle after the issue pulse, so the last stage lines up with simd_rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{valid: simd_issue, keep: iss_keep, last: iss_last};
      for (int i = 1; i < SIMD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    inflight = CW'(simd_issue);
    for (int i = 0; i < SIMD_LAT; i++) inflight = inflight + CW'(tag_pipe[i].valid);
  end

  assign push_res = '{data: simd_rd, keep: tag_pipe[SIMD_LAT-1].keep, last: tag_pipe[SIMD_LAT-1].last};

  neural_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (tag_pipe[SIMD_LAT-1].valid),
    .push_ready (fifo_push_ready),
    .push_data  (push_res),
    .pop_valid  (m_valid),
    .pop_ready  (m_ready),
    .pop_data   (head),
    .count      (fifo_count)
  );

  assign m_data = head.data;
  assign m_keep = head.keep;
  assign m_last = head.last;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    tag_pipe[SIMD_LAT-1].valid |-> fifo_push_ready);

`ifdef NEURAL_FEED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (issue_now && stat_words != '1) stat_words <= stat_words + 32'd1;
      if (word_complete && !credit_ok && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_neural_simd_feeder.sv
// Randomised self-checking bench for neural_simd_feeder with a word-level reference model.
module tb_neural_simd_feeder;
  localparam int SIMD_LAT   = 3;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed { logic [31:0] rs1, rs2, param; logic [1:0] mode; } iss_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } out_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_param = '0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0]  s_pix_t = '0, s_pix_t1 = '0;
  logic [1:0]  simd_mode;
  logic [31:0] simd_rs1, simd_rs2, simd_param, simd_rd;
  logic        simd_issue;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
`ifdef NEURAL_FEED_STATS_EN
  logic [31:0] stat_words, stat_stalls;
`endif

  int errors = 0, checks = 0, tmo = 0, stall_cyc = 0, iss_total = 0;
  bit done;
  iss_t exp_iss[$], got_iss[$];
  out_t exp_out[$], got_out[$];
  logic [31:0] a_rs1, a_rs2;
  logic [3:0]  a_keep;
  logic [1:0]  a_mode;
  logic [7:0]  a_param;
  int          a_lane;

  always #5 clk = ~clk;

  neural_simd_feeder #(.SIMD_LAT(SIMD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_param(cfg_param),
    .s_valid(s_valid), .s_ready(s_ready), .s_pix_t(s_pix_t), .s_pix_t1(s_pix_t1), .s_last(s_last),
    .simd_mode(simd_mode), .simd_rs1(simd_rs1), .simd_rs2(simd_rs2), .simd_param(simd_param),
    .simd_issue(simd_issue), .simd_rd(simd_rd),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
`ifdef NEURAL_FEED_STATS_EN
    , .stat_words(stat_words), .stat_stalls(stat_stalls)
`endif
  );

  // Stand-in SIMD: an arbitrary mixing function delivered SIMD_LAT cycles after issue.
  function automatic logic [31:0] simd_model(input logic [31:0] a, b, p, input logic [1:0] m);
    return (a + b * 32'd3) ^ p ^ {m, 30'h0};
  endfunction

  logic [31:0] rd_pipe [SIMD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= simd_issue ? simd_model(simd_rs1, simd_rs2, simd_param, simd_mode) : 32'hDEADBEEF;
    for (int i = 1; i < SIMD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign simd_rd = rd_pipe[SIMD_LAT-1];

  always @(negedge clk) begin
    if (!rst) begin
      if (simd_issue) begin
        got_iss.push_back('{simd_rs1, simd_rs2, simd_param, simd_mode});
        iss_total++;
      end
      if (m_valid && m_ready) got_out.push_back('{m_data, m_keep, m_last});
    end
  end

  task automatic flush_model();
    exp_iss.delete(); got_iss.delete(); exp_out.delete(); got_out.delete();
    a_rs1 = '0; a_rs2 = '0; a_keep = '0; a_lane = 0;
  endtask

  // Reference packer: whole words built from the accepted byte stream.
  task automatic model_accept(input logic [7:0] t, t1, input logic last, input logic [1:0] mode,
                              input logic [7:0] param);
    if (a_lane == 0) begin a_mode = mode; a_param = param; end
    a_rs1[a_lane*8 +: 8] = t;
    a_rs2[a_lane*8 +: 8] = t1;
    a_keep[a_lane] = 1'b1;
    a_lane++;
    if (a_lane == 4 || last) begin
      exp_iss.push_back('{a_rs1, a_rs2, {4{a_param}}, a_mode});
      exp_out.push_back('{simd_model(a_rs1, a_rs2, {4{a_param}}, a_mode), a_keep, last});
      a_rs1 = '0; a_rs2 = '0; a_keep = '0; a_lane = 0;
    end
  endtask

  task automatic send_pair(input logic [7:0] t, t1, input logic last, input logic [1:0] mode,
                           input logic [7:0] param);
    bit acc = 0;
    s_valid = 1'b1; s_pix_t = t; s_pix_t1 = t1; s_last = last; cfg_mode = mode; cfg_param = param;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (s_ready) acc = 1; else stall_cyc++;
      @(posedge clk); #1;
    end
    if (acc) model_accept(t, t1, last, mode, param); else tmo++;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(posedge clk); #1;
      if (got_out.size() >= exp_out.size() && got_iss.size() >= exp_iss.size()) ok = 1;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    checks++; if ({simd_issue, m_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b want 00", {simd_issue, m_valid}); end
    checks++; if ({simd_rs1, simd_rs2, simd_param, simd_mode, m_data, m_keep, m_last} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h want 0", simd_rs1, simd_rs2, simd_param, m_data); end
    @(posedge clk); #1; rst = 1'b0;
    flush_model();
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    tmo = 0; stall_cyc = 0; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_pair(8'(i + 1), 8'(8'h11 + i), 1'b0, 2'd1, 8'h20);
    wait_drain(ok);
    checks++; if (!ok || tmo != 0) begin errors++; $display("FAIL basic_timeout: ok=%0d tmo=%0d want 1/0", ok, tmo); end
    checks++; if (stall_cyc != 0) begin errors++; $display("FAIL basic_throughput: stalls=%0d want 0", stall_cyc); end
    checks++; if (got_iss.size() != 2) begin errors++; $display("FAIL basic_issue_count: got %0d want 2", got_iss.size()); end
    checks++; if (got_iss[0] !== iss_t'{32'h04030201, 32'h14131211, 32'h20202020, 2'd1}) begin
      errors++; $display("FAIL basic_word0: got %h want 04030201/14131211/20202020/1", got_iss[0]); end
    checks++; if (got_iss[1] !== iss_t'{32'h08070605, 32'h18171615, 32'h20202020, 2'd1}) begin
      errors++; $display("FAIL basic_word1: got %h want 08070605/18171615/20202020/1", got_iss[1]); end
    for (int i = 0; i < exp_out.size(); i++) begin
      checks++; if (got_out[i] !== exp_out[i] || got_out[i].keep !== 4'hF) begin
        errors++; $display("FAIL basic_out%0d: got %h want %h", i, got_out[i], exp_out[i]); end
    end
    flush_model();
  endtask

  task automatic test_partial();
    bit ok;
    tmo = 0;
    for (int i = 0; i < 3; i++) send_pair(8'(i + 1), 8'(8'h11 + i), i == 2, 2'd0, 8'h05);
    wait_drain(ok);
    checks++; if (!ok || tmo != 0 || got_out.size() != 1) begin
      errors++; $display("FAIL partial_count: ok=%0d tmo=%0d outs=%0d want 1/0/1", ok, tmo, got_out.size()); end
    checks++; if (got_iss[0].rs1 !== 32'h00030201) begin errors++; $display("FAIL partial_rs1: got %h want 00030201", got_iss[0].rs1); end
    checks++; if ({got_out[0].keep, got_out[0].last} !== 5'b0111_1) begin
      errors++; $display("FAIL partial_keep_last: got %h/%b want 7/1", got_out[0].keep, got_out[0].last); end
    checks++; if (got_out[0] !== exp_out[0]) begin errors++; $display("FAIL partial_data: got %h want %h", got_out[0], exp_out[0]); end
    flush_model();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [36:0] h;
    tmo = 0; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, 2'($urandom), 8'($urandom));
    repeat (10) @(posedge clk);
    @(negedge clk); h = {m_data, m_keep, m_last};
    repeat (10) @(negedge clk);
    checks++; if (got_iss.size() != 4) begin errors++; $display("FAIL bp_issue_count: got %0d want 4", got_iss.size()); end
    checks++; if ({s_ready, m_valid} !== 2'b01) begin errors++; $display("FAIL bp_flags: s_ready,m_valid=%b want 01", {s_ready, m_valid}); end
    checks++; if ({m_data, m_keep, m_last} !== h || {m_data, m_keep, m_last} !== {exp_out[0].data, exp_out[0].keep, exp_out[0].last}) begin
      errors++; $display("FAIL bp_head_stable: got %h want %h", {m_data, m_keep, m_last}, exp_out[0]); end
    @(posedge clk); #1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, 2'($urandom), 8'($urandom));
    wait_drain(ok);
    checks++; if (!ok || tmo != 0 || got_out.size() != 6) begin
      errors++; $display("FAIL bp_drain: ok=%0d tmo=%0d outs=%0d want 1/0/6", ok, tmo, got_out.size()); end
    for (int i = 0; i < exp_out.size(); i++) begin
      checks++; if (got_out[i] !== exp_out[i] || got_iss[i] !== exp_iss[i]) begin
        errors++; $display("FAIL bp_out%0d: got %h want %h", i, got_out[i], exp_out[i]); end
    end
    flush_model();
  endtask

  task automatic test_mode_change();
    bit ok;
    tmo = 0;
    for (int i = 0; i < 8; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, (i < 2) ? 2'd1 : 2'd2, 8'h33);
    wait_drain(ok);
    checks++; if (!ok || tmo != 0) begin errors++; $display("FAIL mode_timeout: ok=%0d tmo=%0d", ok, tmo); end
    checks++; if ({got_iss[0].mode, got_iss[1].mode} !== 4'b01_10) begin
      errors++; $display("FAIL mode_words: got %0d,%0d want 1,2", got_iss[0].mode, got_iss[1].mode); end
    for (int i = 0; i < exp_out.size(); i++) begin
      checks++; if (got_out[i] !== exp_out[i]) begin errors++; $display("FAIL mode_out%0d: got %h want %h", i, got_out[i], exp_out[i]); end
    end
    flush_model();
  endtask

  task automatic test_reset_mid();
    bit ok;
    tmo = 0; m_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_pair(8'($urandom), 8'($urandom), 1'b0, 2'd3, 8'h44);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({m_valid, simd_issue, s_ready} !== 3'b000) begin
      errors++; $display("FAIL midrst_outputs: got %b want 000", {m_valid, simd_issue, s_ready}); end
    @(posedge clk); #1; rst = 1'b0;
    flush_model(); iss_total = 0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(8'(8'hA0 + i), 8'(8'hB0 + i), 1'b0, 2'd2, 8'h5A);
    wait_drain(ok);
    checks++; if (!ok || tmo != 0 || got_iss.size() != 1 || got_out.size() != 1) begin
      errors++; $display("FAIL midrst_counts: ok=%0d tmo=%0d iss=%0d outs=%0d want 1/0/1/1", ok, tmo, got_iss.size(), got_out.size()); end
    checks++; if (got_iss[0] !== iss_t'{32'hA3A2A1A0, 32'hB3B2B1B0, 32'h5A5A5A5A, 2'd2}) begin
      errors++; $display("FAIL midrst_word: got %h want A3A2A1A0/B3B2B1B0/5A5A5A5A/2", got_iss[0]); end
    checks++; if (got_out[0] !== exp_out[0]) begin errors++; $display("FAIL midrst_out: got %h want %h", got_out[0], exp_out[0]); end
  endtask

  task automatic test_random();
    bit ok;
    tmo = 0; done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_pair(8'($urandom), 8'($urandom), (i == 149) || ($urandom_range(0, 5) == 0),
                    2'($urandom), 8'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_ready = 1'b1;
    wait_drain(ok);
    checks++; if (!ok || tmo != 0 || got_out.size() != exp_out.size() || got_iss.size() != exp_iss.size()) begin
      errors++; $display("FAIL rand_counts: ok=%0d tmo=%0d outs=%0d/%0d iss=%0d/%0d", ok, tmo,
                         got_out.size(), exp_out.size(), got_iss.size(), exp_iss.size()); end
    for (int i = 0; i < exp_out.size(); i++) begin
      checks++; if (got_out[i] !== exp_out[i] || got_iss[i] !== exp_iss[i]) begin
        errors++; $display("FAIL rand_out%0d: got %h/%h want %h/%h", i, got_out[i], got_iss[i], exp_out[i], exp_iss[i]); end
    end
`ifdef NEURAL_FEED_STATS_EN
    checks++; if (stat_words !== 32'(iss_total)) begin
      errors++; $display("FAIL stat_words: got %0d want %0d", stat_words, iss_total); end
`endif
    flush_model();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
